// File: rtl/mem_arbiter.sv
// Two-to-one fetch/data arbiter onto one word-wide memory port; grant to response >= 2 cycles.
// Requesters hold strobes until their one-cycle resp pulse; the memory stalls via mem_resp.
module mem_arbiter #(
    parameter int MAX_D_STREAK = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_read,
    input  logic [31:0] inst_addr,
    output logic        inst_resp,
    output logic [31:0] inst_rdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mbe,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_resp,
    output logic [31:0] data_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_mbe,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [2:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        I_DONE,
        D_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] streak;
    logic [31:0]   addr_q;
    logic [3:0]    mbe_q;
    logic [31:0]   wdata_q;
    logic          is_write;
    logic          data_pend;
    logic          grant_d;
    logic          grant_i;

    // Data wins unless a waiting fetch has already been passed over MAX_D_STREAK times.
    always_comb begin
        data_pend = data_read | data_write;
        grant_d   = data_pend && ((streak < SW'(MAX_D_STREAK)) || !inst_read);
        grant_i   = !grant_d && inst_read;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = D_BUSY;
                end else if (grant_i) begin
                    state_nxt = I_BUSY;
                end
            end
            I_BUSY:  if (mem_resp) state_nxt = I_DONE;
            D_BUSY:  if (mem_resp) state_nxt = D_DONE;
            I_DONE:  state_nxt = IDLE;
            D_DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        inst_resp = 1'b0;
        data_resp = 1'b0;
        case (state)
            I_BUSY:  mem_read  = 1'b1;
            D_BUSY: begin
                mem_read  = !is_write;
                mem_write = is_write;
            end
            I_DONE:  inst_resp = 1'b1;
            D_DONE:  data_resp = 1'b1;
            default: ;
        endcase
    end

    // Request latch, streak counter and read-data holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            mbe_q      <= '0;
            wdata_q    <= '0;
            is_write   <= 1'b0;
            streak     <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            if (state == IDLE) begin
                if (grant_d) begin
                    addr_q   <= data_addr;
                    is_write <= data_write;
                    mbe_q    <= data_write ? data_mbe : 4'hF;
                    wdata_q  <= data_wdata;
                    streak   <= inst_read ? streak + SW'(1) : '0;
                end else if (grant_i) begin
                    addr_q   <= inst_addr;
                    is_write <= 1'b0;
                    mbe_q    <= 4'hF;
                    streak   <= '0;
                end
            end
            if (state == I_BUSY && mem_resp) begin
                inst_rdata <= mem_rdata;
            end
            if (state == D_BUSY && mem_resp && !is_write) begin
                data_rdata <= mem_rdata;
            end
        end
    end

    assign mem_address = addr_q;
    assign mem_mbe     = mbe_q;
    assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected commands/responses,
// a negedge monitor pops and compares; a small memory model answers after lat cycles.
module tb_mem_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  mbe;
        logic [31:0] wdata;
    } cmd_t;

    logic        clk;
    logic        rst;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_resp;
    logic [31:0] data_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          fails = 0;
    int          lat = 1;
    bit          tie = 0;
    logic [31:0] last_drdata = '0;

    cmd_t        exp_c[$];
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];

    mem_arbiter #(.MAX_D_STREAK(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_read  (inst_read),
        .inst_addr  (inst_addr),
        .inst_resp  (inst_resp),
        .inst_rdata (inst_rdata),
        .data_read  (data_read),
        .data_write (data_write),
        .data_mbe   (data_mbe),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_resp  (data_resp),
        .data_rdata (data_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_mbe    (mem_mbe),
        .mem_wdata  (mem_wdata),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mdl(input logic [31:0] a);
        mdl = (a == 32'h60) ? 32'h0000_0013 : ((a ^ 32'h5A5A_0000) + 32'd1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_cmd(input logic [31:0] a, input logic wr, input logic [3:0] m, input logic [31:0] w);
        cmd_t c;
        c.addr  = a;
        c.wr    = wr;
        c.mbe   = m;
        c.wdata = w;
        exp_c.push_back(c);
    endtask

    task automatic wait_resp(input bit is_data, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = is_data ? data_resp : inst_resp;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic fetch_req(input logic [31:0] a);
        exp_i.push_back(mdl(a));
        inst_addr = a;
        inst_read = 1'b1;
        wait_resp(1'b0, "inst_resp_timeout");
        inst_read = 1'b0;
    endtask

    task automatic load_req(input logic [31:0] a);
        last_drdata = mdl(a);
        exp_d.push_back(last_drdata);
        data_addr  = a;
        data_write = 1'b0;
        data_read  = 1'b1;
        wait_resp(1'b1, "data_resp_timeout");
        data_read = 1'b0;
    endtask

    task automatic store_req(input logic [31:0] a, input logic [3:0] m, input logic [31:0] w);
        exp_d.push_back(last_drdata);
        data_addr  = a;
        data_mbe   = m;
        data_wdata = w;
        data_read  = 1'b0;
        data_write = 1'b1;
        wait_resp(1'b1, "store_resp_timeout");
        data_write = 1'b0;
    endtask

    // Memory model: answers after lat command cycles, or constantly when tie is set.
    initial begin
        int cnt;
        cnt       = 0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (tie) begin
                mem_resp  = 1'b1;
                mem_rdata = mdl(mem_address);
            end else if (rst || !(mem_read || mem_write)) begin
                cnt      = 0;
                mem_resp = 1'b0;
            end else begin
                cnt++;
                if (cnt >= lat) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mdl(mem_address);
                    cnt       = 0;
                end else begin
                    mem_resp = 1'b0;
                end
            end
        end
    end

    // Monitor
    initial begin
        cmd_t        cur;
        cmd_t        e;
        bit          active;
        bit          prev_tie;
        int          cmd_len;
        int          cyc;
        int          prev_start;
        logic [31:0] v;
        active     = 1'b0;
        prev_tie   = 1'b0;
        cmd_len    = 0;
        cyc        = 0;
        prev_start = 0;
        cur        = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                active = 1'b0;
            end else begin
                if (mem_read || mem_write) begin
                    chk("rd_wr_exclusive", 32'(mem_read && mem_write), 32'd0);
                    if (!active) begin
                        active     = 1'b1;
                        cmd_len    = 1;
                        cur.addr   = mem_address;
                        cur.wr     = mem_write;
                        cur.mbe    = mem_mbe;
                        cur.wdata  = mem_wdata;
                        if (tie && prev_tie) chk("zero_wait_spacing", 32'(cyc - prev_start), 32'd3);
                        prev_start = cyc;
                        prev_tie   = tie;
                        if (exp_c.size() == 0) begin
                            chk("unexpected_cmd", 32'd1, 32'd0);
                        end else begin
                            e = exp_c.pop_front();
                            chk("cmd_addr", mem_address, e.addr);
                            chk("cmd_write", 32'(mem_write), 32'(e.wr));
                            chk("cmd_mbe", 32'(mem_mbe), 32'(e.mbe));
                            if (e.wr) chk("cmd_wdata", mem_wdata, e.wdata);
                        end
                    end else begin
                        cmd_len++;
                        chk("cmd_stable_addr", mem_address, cur.addr);
                        chk("cmd_stable_mbe", 32'(mem_mbe), 32'(cur.mbe));
                        chk("cmd_stable_wdata", mem_wdata, cur.wdata);
                    end
                end else begin
                    active = 1'b0;
                end
                if (inst_resp) begin
                    chk("inst_resp_cmd_low", 32'(mem_read | mem_write), 32'd0);
                    chk("inst_cmd_len", 32'(cmd_len), 32'(lat));
                    if (exp_i.size() == 0) begin
                        chk("inst_resp_unexpected", 32'd1, 32'd0);
                    end else begin
                        v = exp_i.pop_front();
                        chk("inst_rdata", inst_rdata, v);
                    end
                end
                if (data_resp) begin
                    chk("data_resp_cmd_low", 32'(mem_read | mem_write), 32'd0);
                    chk("data_cmd_len", 32'(cmd_len), 32'(lat));
                    if (exp_d.size() == 0) begin
                        chk("data_resp_unexpected", 32'd1, 32'd0);
                    end else begin
                        v = exp_d.pop_front();
                        chk("data_rdata", data_rdata, v);
                    end
                end
            end
        end
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_mem_read"}, 32'(mem_read), 32'd0);
        chk({nm, "_mem_write"}, 32'(mem_write), 32'd0);
        chk({nm, "_mem_address"}, mem_address, 32'd0);
        chk({nm, "_mem_mbe"}, 32'(mem_mbe), 32'd0);
        chk({nm, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({nm, "_inst_resp"}, 32'(inst_resp), 32'd0);
        chk({nm, "_data_resp"}, 32'(data_resp), 32'd0);
        chk({nm, "_inst_rdata"}, inst_rdata, 32'd0);
        chk({nm, "_data_rdata"}, data_rdata, 32'd0);
    endtask

    // Stimulus
    initial begin
        rst        = 1'b1;
        inst_read  = 1'b0;
        inst_addr  = '0;
        data_read  = 1'b0;
        data_write = 1'b0;
        data_mbe   = '0;
        data_addr  = '0;
        data_wdata = '0;
        idle(3);
        rst = 1'b0;
        chk_all_zero("reset");

        // Single fetch, 3-cycle memory
        lat = 3;
        idle(2);
        exp_cmd(32'h60, 1'b0, 4'hF, 32'h0);
        fetch_req(32'h60);
        idle(2);

        // Simultaneous fetch and load: data first
        lat = 2;
        exp_cmd(32'h1000, 1'b0, 4'hF, 32'h0);
        exp_cmd(32'h64, 1'b0, 4'hF, 32'h0);
        fork
            fetch_req(32'h64);
            load_req(32'h1000);
        join
        idle(2);

        // Store with store data changing mid-transaction
        exp_cmd(32'h2000, 1'b1, 4'hC, 32'hBEEF_0000);
        fork
            store_req(32'h2000, 4'hC, 32'hBEEF_0000);
            begin
                idle(1);
                data_wdata = 32'h1234_5678;
            end
        join
        idle(2);

        // Anti-starvation: D, D, I, D, D, I
        lat = 1;
        exp_cmd(32'h5000, 1'b0, 4'hF, 32'h0);
        exp_cmd(32'h5004, 1'b0, 4'hF, 32'h0);
        exp_cmd(32'h100, 1'b0, 4'hF, 32'h0);
        exp_cmd(32'h5008, 1'b0, 4'hF, 32'h0);
        exp_cmd(32'h500C, 1'b0, 4'hF, 32'h0);
        exp_cmd(32'h104, 1'b0, 4'hF, 32'h0);
        fork
            begin
                fetch_req(32'h100);
                fetch_req(32'h104);
            end
            begin
                load_req(32'h5000);
                load_req(32'h5004);
                load_req(32'h5008);
                load_req(32'h500C);
            end
        join
        idle(2);

        // Reset while in D_BUSY abandons the load
        lat = 6;
        exp_cmd(32'h3000, 1'b0, 4'hF, 32'h0);
        data_addr  = 32'h3000;
        data_write = 1'b0;
        data_read  = 1'b1;
        idle(2);
        rst       = 1'b1;
        data_read = 1'b0;
        idle(1);
        rst         = 1'b0;
        last_drdata = '0;
        chk_all_zero("mid_reset");
        idle(4);
        lat = 2;
        exp_cmd(32'h3004, 1'b0, 4'hF, 32'h0);
        load_req(32'h3004);
        idle(2);

        // Zero-wait memory: mem_resp tied high
        tie = 1'b1;
        lat = 1;
        idle(2);
        exp_cmd(32'h4000, 1'b0, 4'hF, 32'h0);
        exp_cmd(32'h4004, 1'b0, 4'hF, 32'h0);
        exp_cmd(32'h4008, 1'b1, 4'h3, 32'h0000_CAFE);
        exp_cmd(32'h80, 1'b0, 4'hF, 32'h0);
        load_req(32'h4000);
        load_req(32'h4004);
        store_req(32'h4008, 4'h3, 32'h0000_CAFE);
        fetch_req(32'h80);
        idle(1);
        tie = 1'b0;
        idle(3);

        chk("cmd_queue_drained", 32'(exp_c.size()), 32'd0);
        chk("inst_queue_drained", 32'(exp_i.size()), 32'd0);
        chk("data_queue_drained", 32'(exp_d.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
